// File: rtl/axi_ni_target_response_scheduler.sv
// Target NI response scheduler: arbitrates AXI R beats and B responses into a single
// held payload and replays that payload on NACK, up to a retry limit.
module axi_ni_target_response_scheduler #(
  parameter int unsigned AXIRDATAWD   = 32,
  parameter int unsigned RESEND_DELAY = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RETRYCNTWD   = 2,
  parameter int unsigned DLYCNTWD     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXIRDATAWD-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic [AXIRDATAWD-1:0] pl_data,
  output logic [1:0]            pl_resp,
  output logic                  sample_payload,
  output logic                  pkt_valid,
  output logic                  pkt_is_read,
  output logic                  pkt_last,
  input  logic                  pkt_ready,
  input  logic                  pkt_nack,
  output logic                  retry_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [RETRYCNTWD-1:0] retry_cnt, retry_cnt_nxt;
  logic [DLYCNTWD-1:0]   dly_cnt, dly_cnt_nxt;
  logic                  retry_fail_nxt;
  logic                  grant_r, grant_b;
  logic                  last_grant_r;
  logic                  r_burst_open;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      retry_cnt <= '0;
      dly_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_cnt_nxt;
      dly_cnt   <= dly_cnt_nxt;
    end
  end

  // Next state, arbitration and the combinational AXI handshake / payload mux
  always_comb begin
    state_nxt      = state;
    retry_cnt_nxt  = retry_cnt;
    dly_cnt_nxt    = dly_cnt;
    retry_fail_nxt = 1'b0;
    grant_r        = 1'b0;
    grant_b        = 1'b0;
    rready         = 1'b0;
    bready         = 1'b0;
    sample_payload = 1'b0;
    pl_data        = '0;
    pl_resp        = 2'b00;
    case (state)
      IDLE: begin
        if (!rst) begin
          // An open R burst owns the channel; otherwise round-robin on ties
          if (r_burst_open) begin
            grant_r = rvalid;
          end else if (rvalid && bvalid) begin
            grant_r = ~last_grant_r;
            grant_b = last_grant_r;
          end else begin
            grant_r = rvalid;
            grant_b = bvalid;
          end
        end
        rready         = grant_r;
        bready         = grant_b;
        sample_payload = grant_r | grant_b;
        pl_data        = grant_r ? rdata : '0;
        pl_resp        = grant_r ? rresp : (grant_b ? bresp : 2'b00);
        if (grant_r || grant_b) begin
          retry_cnt_nxt = '0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (pkt_ready) begin
          if (!pkt_nack) begin
            state_nxt = IDLE;
          end else if (retry_cnt < RETRYCNTWD'(MAX_RETRY)) begin
            retry_cnt_nxt = retry_cnt + RETRYCNTWD'(1);
            dly_cnt_nxt   = DLYCNTWD'(RESEND_DELAY);
            state_nxt     = WAIT;
          end else begin
            retry_fail_nxt = 1'b1;
            state_nxt      = IDLE;
          end
        end
      end
      WAIT: begin
        dly_cnt_nxt = dly_cnt - DLYCNTWD'(1);
        if (dly_cnt == DLYCNTWD'(1)) begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Held-payload attributes, arbitration history and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_valid    <= 1'b0;
      retry_fail   <= 1'b0;
      pkt_is_read  <= 1'b0;
      pkt_last     <= 1'b0;
      last_grant_r <= 1'b0;
      r_burst_open <= 1'b0;
    end else begin
      pkt_valid  <= (state_nxt == SEND);
      retry_fail <= retry_fail_nxt;
      if (sample_payload) begin
        pkt_is_read  <= grant_r;
        pkt_last     <= grant_r ? rlast : 1'b1;
        last_grant_r <= grant_r;
        r_burst_open <= grant_r & ~rlast;
      end
    end
  end

endmodule

// File: tb/tb_axi_ni_target_response_scheduler.sv
// Randomized bench for the target NI response scheduler against a transaction-level
// model of the held payload, its retry budget and the R/B arbitration history.
module tb_axi_ni_target_response_scheduler;

  localparam int unsigned DW   = 32;
  localparam int unsigned DLY  = 4;
  localparam int unsigned MAXR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rvalid, rready, rlast;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic [DW-1:0] pl_data;
  logic [1:0]    pl_resp;
  logic          sample_payload, pkt_valid, pkt_is_read, pkt_last;
  logic          pkt_ready, pkt_nack, retry_fail;

  always #5 clk = ~clk;

  axi_ni_target_response_scheduler #(
    .AXIRDATAWD(DW), .RESEND_DELAY(DLY), .MAX_RETRY(MAXR), .RETRYCNTWD(2), .DLYCNTWD(3)
  ) dut (
    .clk(clk), .rst(rst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .pl_data(pl_data), .pl_resp(pl_resp), .sample_payload(sample_payload),
    .pkt_valid(pkt_valid), .pkt_is_read(pkt_is_read), .pkt_last(pkt_last),
    .pkt_ready(pkt_ready), .pkt_nack(pkt_nack), .retry_fail(retry_fail)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one held payload, its replay bookkeeping and the arbitration history
  bit m_held, m_rd, m_last, m_last_r, m_burst, m_fail;
  int m_wait, m_tries;
  int n_fail_seen = 0;

  // Traffic sources and knobs
  bit r_hs, b_hs, src_en;
  int r_left;
  int p_r, p_b, p_ready, p_nack;

  task automatic model_clear();
    m_held = 0; m_rd = 0; m_last = 0; m_last_r = 0; m_burst = 0; m_fail = 0;
    m_wait = 0; m_tries = 0; r_hs = 0; b_hs = 0;
  endtask

  task automatic drive();
    if (r_hs) rvalid = 1'b0;
    if (b_hs) bvalid = 1'b0;
    r_hs = 0;
    b_hs = 0;
    if (!rvalid && src_en) begin
      if (r_left == 0 && $urandom_range(99) < p_r) r_left = int'($urandom_range(4, 1));
      if (r_left > 0 && $urandom_range(99) < 70) begin
        r_left--;
        rvalid = 1'b1;
        rdata  = DW'($urandom);
        rresp  = 2'($urandom);
        rlast  = (r_left == 0);
      end
    end
    if (!bvalid && src_en && $urandom_range(99) < p_b) begin
      bvalid = 1'b1;
      bresp  = 2'($urandom);
    end
    pkt_ready = ($urandom_range(99) < p_ready);
    pkt_nack  = ($urandom_range(99) < p_nack);
  endtask

  task automatic eval();
    bit gr, gb, fail_n;
    gr = 0;
    gb = 0;
    if (!m_held) begin
      if (m_burst) gr = rvalid;
      else if (rvalid && bvalid) begin gr = !m_last_r; gb = m_last_r; end
      else begin gr = rvalid; gb = bvalid; end
    end
    check("rready", 64'(rready), 64'(gr));
    check("bready", 64'(bready), 64'(gb));
    check("sample_payload", 64'(sample_payload), 64'(gr | gb));
    if (gr || gb) begin
      check("pl_data", 64'(pl_data), gr ? 64'(rdata) : 64'(0));
      check("pl_resp", 64'(pl_resp), gr ? 64'(rresp) : 64'(bresp));
    end
    check("pkt_valid", 64'(pkt_valid), 64'(m_held && m_wait == 0));
    check("retry_fail", 64'(retry_fail), 64'(m_fail));
    if (m_fail) n_fail_seen++;
    if (m_held && m_wait == 0) begin
      check("pkt_is_read", 64'(pkt_is_read), 64'(m_rd));
      check("pkt_last", 64'(pkt_last), 64'(m_last));
    end
    fail_n = 0;
    if (gr || gb) begin
      m_held = 1; m_rd = gr; m_last = gr ? rlast : 1'b1;
      m_tries = 0; m_wait = 0; m_last_r = gr; m_burst = gr && rlast == 1'b0;
    end else if (m_held && m_wait > 0) begin
      m_wait--;
    end else if (m_held && pkt_ready) begin
      if (!pkt_nack) m_held = 0;
      else if (m_tries < int'(MAXR)) begin m_tries++; m_wait = DLY; end
      else begin m_held = 0; fail_n = 1; end
    end
    m_fail = fail_n;
    r_hs = gr;
    b_hs = gb;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      eval();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pkt_valid"}, 64'(pkt_valid), 64'(0));
    check({tag, "_retry_fail"}, 64'(retry_fail), 64'(0));
    check({tag, "_pkt_is_read"}, 64'(pkt_is_read), 64'(0));
    check({tag, "_pkt_last"}, 64'(pkt_last), 64'(0));
    check({tag, "_rready"}, 64'(rready), 64'(0));
    check({tag, "_bready"}, 64'(bready), 64'(0));
    check({tag, "_sample"}, 64'(sample_payload), 64'(0));
  endtask

  initial begin
    int guard;
    rst = 1'b1; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; bvalid = 0; bresp = 0;
    pkt_ready = 0; pkt_nack = 0; src_en = 0; r_left = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // First grant from reset on a tie must go to R
    rvalid = 1; rdata = DW'(32'hA5A5_0001); rresp = 2'b01; rlast = 1; bvalid = 1; bresp = 2'b10;
    @(negedge clk);
    check("tie_first_r", 64'(rready), 64'(1));
    check("tie_first_no_b", 64'(bready), 64'(0));
    eval();

    src_en = 1;
    p_r = 40; p_b = 40; p_ready = 70; p_nack = 15;
    run(3000);
    p_nack = 90;
    run(1500);
    check("retry_fail_observed", 64'(n_fail_seen > 0), 64'(1));
    p_r = 60; p_b = 60; p_ready = 100; p_nack = 0;
    run(800);

    // Drive into the NACK back-off, then reset while waiting
    p_ready = 100; p_nack = 100;
    guard = 0;
    while (m_wait == 0 && guard < 100) begin
      run(1);
      guard++;
    end
    check("reach_wait", 64'(m_wait > 0), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    rvalid = 1; rlast = 1; bvalid = 1;
    @(negedge clk);
    check("rst_rready", 64'(rready), 64'(0));
    check("rst_bready", 64'(bready), 64'(0));
    check("rst_sample", 64'(sample_payload), 64'(0));
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    eval();

    p_ready = 70; p_nack = 20;
    run(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
